// File: rtl/text_line_assembler.sv
// rtl/text_line_assembler.sv - collects received bytes into a padded fixed-width text line
module text_line_assembler #(
    parameter int         LINE_MAX = 79,
    parameter logic [7:0] PAD_CHAR = 8'h20
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    output logic       o_rx_ready,
    input  logic [6:0] i_rd_addr,
    output logic [7:0] o_rd_data,
    output logic       o_line_valid,
    output logic [6:0] o_line_len,
    input  logic       i_line_ack,
    output logic       o_dropped
);

    localparam logic [6:0] LINE_MAX_W = 7'(LINE_MAX);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        PAD     = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [6:0] len;
    logic [6:0] len_next;
    logic [6:0] pad_idx;
    logic       cr_seen;
    logic       dropped;
    logic [7:0] buffer [LINE_MAX];

    logic accept;
    logic is_print;
    logic is_bs;
    logic is_cr;
    logic is_lf;
    logic store;
    logic back;
    logic term;
    logic full;
    logic drop;
    logic pad_write;

    // Byte classification and the actions it triggers while collecting
    always_comb begin
        accept    = i_rx_valid && (state == COLLECT);
        is_print  = (i_rx_data >= 8'h20) && (i_rx_data <= 8'h7E);
        is_bs     = (i_rx_data == 8'h08);
        is_cr     = (i_rx_data == 8'h0D);
        is_lf     = (i_rx_data == 8'h0A);
        store     = accept && is_print && (len < LINE_MAX_W);
        back      = accept && is_bs && (len != 7'd0);
        // An LF right after a CR terminator is the tail of a CR-LF pair, not a new line
        term      = accept && (is_cr || (is_lf && !cr_seen));
        full      = store && (len == LINE_MAX_W - 7'd1);
        drop      = accept && !(is_print || is_bs || is_cr || is_lf);
        pad_write = (state == PAD) && (pad_idx < LINE_MAX_W);
        len_next  = len;
        if (store) begin
            len_next = len + 7'd1;
        end else if (back) begin
            len_next = len - 7'd1;
        end
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (term || full) state_next = PAD;
            PAD:     if (pad_idx >= LINE_MAX_W - 7'd1) state_next = HOLD;
            HOLD:    if (i_line_ack) state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    // Output decode from the current state
    always_comb begin
        o_rx_ready   = 1'b0;
        o_line_valid = 1'b0;
        o_line_len   = 7'd0;
        case (state)
            COLLECT: o_rx_ready = 1'b1;
            HOLD: begin
                o_line_valid = 1'b1;
                o_line_len   = len;
            end
            default: ;
        endcase
    end

    // Line length, pad cursor, CR tracking and the sticky drop flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            len     <= 7'd0;
            pad_idx <= 7'd0;
            cr_seen <= 1'b0;
            dropped <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    len     <= len_next;
                    pad_idx <= len_next;
                    if (accept) cr_seen <= is_cr;
                    if (drop) dropped <= 1'b1;
                end
                PAD: begin
                    if (pad_write) pad_idx <= pad_idx + 7'd1;
                end
                HOLD: begin
                    if (i_line_ack) begin
                        len     <= 7'd0;
                        dropped <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_dropped = dropped;

    // Line buffer writes: typed characters while collecting, pad fill afterwards
    always_ff @(posedge i_clk) begin
        if (store) begin
            buffer[len] <= i_rx_data;
        end else if (pad_write) begin
            buffer[pad_idx] <= PAD_CHAR;
        end
    end

    // Registered read port; indices past the line read as padding
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_data <= PAD_CHAR;
        end else if (i_rd_addr < LINE_MAX_W) begin
            o_rd_data <= buffer[i_rd_addr];
        end else begin
            o_rd_data <= PAD_CHAR;
        end
    end

endmodule

// File: tb/tb_text_line_assembler.sv
// tb/tb_text_line_assembler.sv - directed self-checking bench for text_line_assembler
module tb_text_line_assembler;

    logic       i_clk;
    logic       i_rst_n;
    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic       o_rx_ready;
    logic [6:0] i_rd_addr;
    logic [7:0] o_rd_data;
    logic       o_line_valid;
    logic [6:0] o_line_len;
    logic       i_line_ack;
    logic       o_dropped;

    int checks = 0;
    int errors = 0;

    text_line_assembler dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_rx_data   (i_rx_data),
        .i_rx_valid  (i_rx_valid),
        .o_rx_ready  (o_rx_ready),
        .i_rd_addr   (i_rd_addr),
        .o_rd_data   (o_rd_data),
        .o_line_valid(o_line_valid),
        .o_line_len  (o_line_len),
        .i_line_ack  (i_line_ack),
        .o_dropped   (o_dropped)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        while (!o_rx_ready && n < 300) begin
            tick();
            n++;
        end
        if (!o_rx_ready) check("send_timeout", 0, 1);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        tick();
        i_rx_valid = 1'b0;
    endtask

    task automatic wait_hold(output int n);
        n = 0;
        while (!o_line_valid && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic read_cell(input logic [6:0] addr, output logic [7:0] d);
        i_rd_addr = addr;
        tick();
        d = o_rd_data;
    endtask

    task automatic ack_line();
        i_line_ack = 1'b1;
        tick();
        i_line_ack = 1'b0;
    endtask

    initial begin
        int         n;
        logic [7:0] d;

        i_rst_n    = 1'b0;
        i_rx_data  = 8'h00;
        i_rx_valid = 1'b0;
        i_rd_addr  = 7'd0;
        i_line_ack = 1'b0;
        repeat (3) tick();

        check("rst_ready", o_rx_ready, 1);
        check("rst_valid", o_line_valid, 0);
        check("rst_len", o_line_len, 0);
        check("rst_dropped", o_dropped, 0);
        check("rst_rd_data", o_rd_data, 8'h20);
        i_rst_n = 1'b1;
        tick();

        // "hi" CR
        send_byte(8'h68);
        send_byte(8'h69);
        send_byte(8'h0D);
        wait_hold(n);
        check("hi_pad_cycles", n, 77);
        check("hi_valid", o_line_valid, 1);
        check("hi_len", o_line_len, 2);
        check("hi_ready_held", o_rx_ready, 0);
        read_cell(7'd0, d);  check("hi_cell0", d, 8'h68);
        read_cell(7'd1, d);  check("hi_cell1", d, 8'h69);
        read_cell(7'd2, d);  check("hi_cell2", d, 8'h20);
        read_cell(7'd78, d); check("hi_cell78", d, 8'h20);
        read_cell(7'd100, d); check("hi_cell100", d, 8'h20);
        repeat (3) tick();
        check("hi_len_stable", o_line_len, 2);
        ack_line();
        check("hi_ack_valid", o_line_valid, 0);
        check("hi_ack_ready", o_rx_ready, 1);

        // "ab" BS "c" CR
        send_byte(8'h61);
        send_byte(8'h62);
        send_byte(8'h08);
        send_byte(8'h63);
        send_byte(8'h0D);
        wait_hold(n);
        check("bs_valid", o_line_valid, 1);
        check("bs_len", o_line_len, 2);
        read_cell(7'd0, d); check("bs_cell0", d, 8'h61);
        read_cell(7'd1, d); check("bs_cell1", d, 8'h63);
        read_cell(7'd2, d); check("bs_cell2", d, 8'h20);
        ack_line();

        // backspace at len 0 then CR
        send_byte(8'h08);
        send_byte(8'h0D);
        wait_hold(n);
        check("bs0_pad_cycles", n, 79);
        check("bs0_len", o_line_len, 0);
        ack_line();

        // 79 printable bytes, no terminator
        for (int i = 0; i < 79; i++) send_byte(8'h41 + 8'(i % 26));
        wait_hold(n);
        check("full_pad_cycles", n, 1);
        check("full_len", o_line_len, 79);
        check("full_ready", o_rx_ready, 0);
        i_rx_data  = 8'h5A;
        i_rx_valid = 1'b1;
        repeat (5) tick();
        check("full_ready_busy", o_rx_ready, 0);
        check("full_len_stable", o_line_len, 79);
        i_rx_valid = 1'b0;
        read_cell(7'd0, d);  check("full_cell0", d, 8'h41);
        read_cell(7'd25, d); check("full_cell25", d, 8'h5A);
        read_cell(7'd78, d); check("full_cell78", d, 8'h41);
        ack_line();

        // CR LF -> one empty line, then a lone LF -> another empty line
        send_byte(8'h0D);
        wait_hold(n);
        check("crlf_valid", o_line_valid, 1);
        check("crlf_len", o_line_len, 0);
        ack_line();
        send_byte(8'h0A);
        repeat (3) tick();
        check("crlf_lf_ready", o_rx_ready, 1);
        check("crlf_lf_no_line", o_line_valid, 0);
        send_byte(8'h0A);
        wait_hold(n);
        check("lf_valid", o_line_valid, 1);
        check("lf_len", o_line_len, 0);
        ack_line();

        // "x" 0x01 "y" CR -> dropped flag
        send_byte(8'h78);
        send_byte(8'h01);
        check("drop_set", o_dropped, 1);
        send_byte(8'h79);
        send_byte(8'h0D);
        wait_hold(n);
        check("drop_len", o_line_len, 2);
        check("drop_held", o_dropped, 1);
        read_cell(7'd1, d); check("drop_cell1", d, 8'h79);
        ack_line();
        check("drop_cleared", o_dropped, 0);
        check("drop_valid_off", o_line_valid, 0);

        // asynchronous reset during HOLD
        send_byte(8'h71);
        send_byte(8'h02);
        send_byte(8'h0D);
        wait_hold(n);
        check("rsth_valid_pre", o_line_valid, 1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("rsth_valid", o_line_valid, 0);
        check("rsth_len", o_line_len, 0);
        check("rsth_dropped", o_dropped, 0);
        check("rsth_ready", o_rx_ready, 1);
        check("rsth_rd_data", o_rd_data, 8'h20);
        tick();
        i_rst_n = 1'b1;
        send_byte(8'h6F);
        send_byte(8'h6B);
        send_byte(8'h0D);
        wait_hold(n);
        check("post_pad_cycles", n, 77);
        check("post_len", o_line_len, 2);
        read_cell(7'd0, d); check("post_cell0", d, 8'h6F);
        read_cell(7'd1, d); check("post_cell1", d, 8'h6B);
        read_cell(7'd2, d); check("post_cell2", d, 8'h20);
        ack_line();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_line_assembler.md
TEXT_LINE_ASSEMBLER -- requirements
Module: text_line_assembler

Interface
REQ-001 SHALL have parameter LINE_MAX, default 79, the number of character cells per line.
REQ-002 SHALL have parameter PAD_CHAR, default 8'h20, the value written into unused cells.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_rx_data, input, 8, incoming byte from the UART/keyboard receiver.
REQ-006 SHALL have port i_rx_valid, input, 1, i_rx_data valid this cycle.
REQ-007 SHALL have port o_rx_ready, output, 1, block accepts a byte this cycle.
REQ-008 SHALL have port i_rd_addr, input, 7, line-buffer read index from the text_to_VGA writer.
REQ-009 SHALL have port o_rd_data, output, 8, registered line-buffer read data.
REQ-010 SHALL have port o_line_valid, output, 1, a complete line is held for the downstream writer.
REQ-011 SHALL have port o_line_len, output, 7, count of typed characters in the held line (0..LINE_MAX).
REQ-012 SHALL have port i_line_ack, input, 1, downstream has consumed the held line.
REQ-013 SHALL have port o_dropped, output, 1, sticky flag for discarded bytes in the current line.

Function
REQ-014 SHALL transfer a byte only on a cycle where i_rx_valid and o_rx_ready are both 1.
REQ-015 SHALL implement states COLLECT, PAD, HOLD, with o_rx_ready = 1 only in COLLECT.
REQ-016 In COLLECT, on an accepted printable byte (8'h20..8'h7E) SHALL store it at buffer[len] and increment len.
REQ-017 In COLLECT, when len reaches LINE_MAX after a store, SHALL go to PAD on the next edge.
REQ-018 In COLLECT, on accepted 8'h08 (backspace) SHALL decrement len if len > 0, and otherwise ignore it.
REQ-019 In COLLECT, on accepted 8'h0D or 8'h0A SHALL go to PAD, including with len = 0 (empty line).
REQ-020 SHALL discard an accepted 8'h0A that immediately follows an accepted 8'h0D terminator, so CR-LF gives one line.
REQ-021 SHALL discard all other accepted bytes and set o_dropped; o_dropped stays set until the line is acked.
REQ-022 In PAD, SHALL write PAD_CHAR to one cell per cycle from index len up to LINE_MAX-1, then enter HOLD.
REQ-023 With len = LINE_MAX at PAD entry, SHALL enter HOLD after one cycle.
REQ-024 In HOLD, SHALL drive o_line_valid = 1 and o_line_len = len; both stay stable until ack.
REQ-025 On i_line_ack = 1 in HOLD, SHALL clear len and o_dropped, drop o_line_valid, and enter COLLECT on the next edge.
REQ-026 SHALL ignore i_line_ack in COLLECT and PAD.
REQ-027 SHALL register o_rd_data = buffer[i_rd_addr] every cycle with 1-cycle latency, in any state.
REQ-028 SHALL return PAD_CHAR on o_rd_data for i_rd_addr >= LINE_MAX.
REQ-029 SHALL guarantee that buffer reads during HOLD return exactly the typed characters followed by PAD_CHAR.
REQ-030 SHALL keep len within 0..LINE_MAX at all times, with no wrap-around.

Reset
REQ-031 While i_rst_n = 0, SHALL force COLLECT state, len = 0, o_line_valid = 0, o_line_len = 0, o_dropped = 0, o_rd_data = PAD_CHAR, and the CR-seen flag = 0.
REQ-032 SHALL leave buffer contents unreset; PAD guarantees defined contents before HOLD.
REQ-033 An assertion of reset mid-PAD or mid-HOLD SHALL abandon the line; after release, o_rx_ready = 1 on the first edge.

Verification
REQ-034 Bench SHALL cover: bytes "hi",8'h0D -> PAD 77 cycles, then o_line_valid=1, o_line_len=2, reads 0..2 = 8'h68,8'h69,8'h20, read 78 = 8'h20.
REQ-035 Bench SHALL cover: "ab",8'h08,"c",8'h0D -> o_line_len=2, cells = 8'h61,8'h63; then 8'h08 at len 0 -> len stays 0.
REQ-036 Bench SHALL cover: 79 printable bytes with no terminator -> HOLD after 1 PAD cycle, o_line_len=79, o_rx_ready=0 while held, and extra i_rx_valid bytes are not accepted.
REQ-037 Bench SHALL cover: 8'h0D,8'h0A -> one empty line (o_line_len=0); after ack, the 8'h0A is not a second line; the next 8'h0A alone gives an empty line.
REQ-038 Bench SHALL cover: byte 8'h01 inside "x",8'h01,"y",8'h0D -> o_dropped=1, o_line_len=2; after i_line_ack, o_dropped=0 and o_line_valid=0 on the next cycle.
REQ-039 Bench SHALL cover: i_rst_n pulsed low during HOLD -> outputs at reset values immediately (asynchronous), then a new line is collected correctly.
